// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-ported memory channel and
// steers in-order memory responses back to the issuing interface as registered pulses.
module mem_req_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter logic [1:0]  IFETCH_OP   = 2'b01
) (
  input  logic        CLK,
  input  logic        RESET,
  // Instruction fetch interface
  input  logic        i_req_valid,
  input  logic [63:0] i_req_pc,
  output logic        i_req_ready,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_instr,
  output logic [1:0]  i_resp_fault,
  // Data access interface
  input  logic        d_req_valid,
  input  logic [1:0]  d_req_op,
  input  logic [7:0]  d_req_mask,
  input  logic [63:0] d_req_addr,
  input  logic [63:0] d_req_data,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_data,
  output logic [1:0]  d_resp_fault,
  // Memory port
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [1:0]  mem_req_op,
  output logic [7:0]  mem_req_mask,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic [1:0]  mem_resp_fault,
  output logic        err_orphan
);

  localparam int unsigned PtrW = $clog2(OUTSTANDING);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(OUTSTANDING);

  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          count_q;
  logic [OUTSTANDING-1:0] tag_src_i_q;
  logic [OUTSTANDING-1:0] tag_hi_q;
  logic                   last_i_q;

  logic        i_resp_valid_q, d_resp_valid_q, err_orphan_q;
  logic [31:0] i_resp_instr_q;
  logic [1:0]  i_resp_fault_q, d_resp_fault_q;
  logic [63:0] d_resp_data_q;

  logic full, can_issue, grant_i, push, pop, head_src_i, head_hi;

  // Fetches are word aligned; the low PC bits carry no information.
  logic unused_pc;
  assign unused_pc = ^i_req_pc[1:0];

  always_comb begin
    full          = (count_q == FullCnt);
    can_issue     = mem_req_ready & ~full;
    // Round robin only matters on a conflict; otherwise the lone requester wins.
    grant_i       = (i_req_valid & d_req_valid) ? ~last_i_q : i_req_valid;
    mem_req_valid = (i_req_valid | d_req_valid) & ~full;
    i_req_ready   = can_issue & i_req_valid & grant_i;
    d_req_ready   = can_issue & d_req_valid & ~grant_i;

    if (grant_i) begin
      mem_req_op   = IFETCH_OP;
      mem_req_mask = i_req_pc[2] ? 8'hF0 : 8'h0F;
      mem_req_addr = {i_req_pc[63:3], 3'b000};
      mem_req_data = '0;
    end else begin
      mem_req_op   = d_req_op;
      mem_req_mask = d_req_mask;
      mem_req_addr = d_req_addr;
      mem_req_data = d_req_data;
    end

    push       = mem_req_valid & mem_req_ready;
    pop        = mem_resp_valid & (count_q != '0);
    head_src_i = tag_src_i_q[rd_ptr_q];
    head_hi    = tag_hi_q[rd_ptr_q];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_i_q       <= 1'b1;
      i_resp_valid_q <= 1'b0;
      i_resp_instr_q <= '0;
      i_resp_fault_q <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
      d_resp_fault_q <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (i_req_valid & d_req_valid & can_issue) last_i_q <= grant_i;

      i_resp_valid_q <= pop & head_src_i;
      d_resp_valid_q <= pop & ~head_src_i;
      if (pop & head_src_i) begin
        i_resp_instr_q <= head_hi ? mem_resp_data[63:32] : mem_resp_data[31:0];
        i_resp_fault_q <= mem_resp_fault;
      end
      if (pop & ~head_src_i) begin
        d_resp_data_q  <= mem_resp_data;
        d_resp_fault_q <= mem_resp_fault;
      end
      if (mem_resp_valid & (count_q == '0)) err_orphan_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read below count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      tag_src_i_q[wr_ptr_q] <= grant_i;
      tag_hi_q[wr_ptr_q]    <= grant_i & i_req_pc[2];
    end
  end

  assign i_resp_valid = i_resp_valid_q;
  assign i_resp_instr = i_resp_instr_q;
  assign i_resp_fault = i_resp_fault_q;
  assign d_resp_valid = d_resp_valid_q;
  assign d_resp_data  = d_resp_data_q;
  assign d_resp_fault = d_resp_fault_q;
  assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_mem_req_arbiter;

  localparam int unsigned OUTSTANDING = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [63:0] i_req_pc;
  logic [31:0] i_resp_instr;
  logic [1:0]  i_resp_fault;
  logic        d_req_valid, d_req_ready, d_resp_valid;
  logic [1:0]  d_req_op, d_resp_fault;
  logic [7:0]  d_req_mask;
  logic [63:0] d_req_addr, d_req_data, d_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, err_orphan;
  logic [1:0]  mem_req_op, mem_resp_fault;
  logic [7:0]  mem_req_mask;
  logic [63:0] mem_req_addr, mem_req_data, mem_resp_data;

  int n_cmp = 0;
  int n_fail = 0;

  mem_req_arbiter #(.OUTSTANDING(OUTSTANDING), .IFETCH_OP(2'b01)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_instr(i_resp_instr), .i_resp_fault(i_resp_fault),
    .d_req_valid(d_req_valid), .d_req_op(d_req_op), .d_req_mask(d_req_mask),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_fault(d_resp_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_op(mem_req_op),
    .mem_req_mask(mem_req_mask), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_fault(mem_resp_fault), .err_orphan(err_orphan)
  );

  always #5 CLK = ~CLK;

  // Reference model: an in-order list of who is waiting for a response.
  typedef struct packed {logic src_i; logic hi;} ent_t;
  ent_t        mq[$];
  logic        m_last_i = 1'b1;
  logic        m_err = 1'b0;
  logic        m_iv = 1'b0, m_dv = 1'b0;
  logic [31:0] m_instr = '0;
  logic [1:0]  m_ifault = '0, m_dfault = '0;
  logic [63:0] m_ddata = '0;

  logic        e_gi, e_can, e_mvalid, e_iready, e_dready;
  logic [1:0]  e_op;
  logic [7:0]  e_mask;
  logic [63:0] e_addr, e_data;

  function automatic void exp_comb();
    logic full;
    full     = (mq.size() == OUTSTANDING);
    e_gi     = (i_req_valid && d_req_valid) ? !m_last_i : i_req_valid;
    e_can    = mem_req_ready && !full;
    e_mvalid = (i_req_valid || d_req_valid) && !full;
    e_iready = e_can && i_req_valid && e_gi;
    e_dready = e_can && d_req_valid && !e_gi;
    if (e_gi) begin
      e_op   = 2'b01;
      e_mask = i_req_pc[2] ? 8'hF0 : 8'h0F;
      e_addr = i_req_pc & ~64'h7;
      e_data = 64'h0;
    end else begin
      e_op   = d_req_op;
      e_mask = d_req_mask;
      e_addr = d_req_addr;
      e_data = d_req_data;
    end
  endfunction

  function automatic void model_seq();
    ent_t h, n;
    if (!RESET) begin
      mq.delete();
      m_last_i = 1'b1; m_err = 1'b0; m_iv = 1'b0; m_dv = 1'b0;
      m_instr = '0; m_ifault = '0; m_dfault = '0; m_ddata = '0;
      return;
    end
    exp_comb();
    m_iv = 1'b0;
    m_dv = 1'b0;
    if (mem_resp_valid && mq.size() == 0) m_err = 1'b1;
    if (mem_resp_valid && mq.size() > 0) begin
      h = mq.pop_front();
      if (h.src_i) begin
        m_iv     = 1'b1;
        m_instr  = h.hi ? mem_resp_data[63:32] : mem_resp_data[31:0];
        m_ifault = mem_resp_fault;
      end else begin
        m_dv     = 1'b1;
        m_ddata  = mem_resp_data;
        m_dfault = mem_resp_fault;
      end
    end
    if (e_mvalid && mem_req_ready) begin
      n.src_i = e_gi;
      n.hi    = e_gi && i_req_pc[2];
      mq.push_back(n);
    end
    if (i_req_valid && d_req_valid && e_can) m_last_i = e_gi;
  endfunction

  task automatic tick();
    model_seq();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    i_req_valid = 1'b0; d_req_valid = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    mem_req_ready = 1'b1;
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 2 * OUTSTANDING && mq.size() > 0; k++) begin
      mem_resp_valid = 1'b1;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset();
    i_req_pc = '0; d_req_op = '0; d_req_mask = '0; d_req_addr = '0; d_req_data = '0;
    mem_resp_data = '0; mem_resp_fault = '0;
    do_reset();
    n_cmp++; if (i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_i_resp_valid got %b want 0", i_resp_valid); end
    n_cmp++; if (d_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_resp_valid got %b want 0", d_resp_valid); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err_orphan got %b want 0", err_orphan); end
    n_cmp++; if (i_resp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_i_resp_instr got %h want 0", i_resp_instr); end
    n_cmp++; if (d_resp_data !== 64'h0) begin n_fail++; $display("FAIL reset_d_resp_data got %h want 0", d_resp_data); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_req_valid = 1'b1; i_req_pc = 64'h1004;
    #1;
    n_cmp++; if (mem_req_addr !== 64'h1000) begin n_fail++; $display("FAIL fetch_addr got %h want 1000", mem_req_addr); end
    n_cmp++; if (mem_req_mask !== 8'hF0) begin n_fail++; $display("FAIL fetch_mask got %h want f0", mem_req_mask); end
    n_cmp++; if (mem_req_op !== 2'b01) begin n_fail++; $display("FAIL fetch_op got %b want 01", mem_req_op); end
    n_cmp++; if ({mem_req_valid, i_req_ready} !== 2'b11) begin n_fail++; $display("FAIL fetch_handshake got %b want 11", {mem_req_valid, i_req_ready}); end
    tick();
    idle();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hDEADBEEF_12345678; mem_resp_fault = 2'b00;
    tick();
    idle();
    n_cmp++; if (i_resp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_resp_valid got %b want 1", i_resp_valid); end
    n_cmp++; if (i_resp_instr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_instr got %h want deadbeef", i_resp_instr); end
    n_cmp++; if (d_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_d_resp got %b want 0", d_resp_valid); end
    tick();
    n_cmp++; if (i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width got %b want 0", i_resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [63:0] rd;
    do_reset();
    i_req_valid = 1'b1; i_req_pc = 64'h2004;
    d_req_valid = 1'b1; d_req_op = 2'b10; d_req_mask = 8'hFF; d_req_addr = 64'h8000;
    d_req_data = 64'h55;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({i_req_ready, d_req_ready} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant_%0d got i/d %b", k, {i_req_ready, d_req_ready});
      end
      n_cmp++; if (mem_req_addr !== ((k % 2 == 1) ? 64'h2000 : 64'h8000)) begin
        n_fail++; $display("FAIL rr_addr_%0d got %h", k, mem_req_addr);
      end
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd = {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)};
      mem_resp_valid = 1'b1; mem_resp_data = rd; mem_resp_fault = 2'(k);
      tick();
      if (k % 2 == 1) begin
        n_cmp++; if ({i_resp_valid, d_resp_valid, i_resp_instr} !== {2'b10, rd[63:32]}) begin
          n_fail++; $display("FAIL rr_route_%0d got iv=%b dv=%b instr=%h want fetch %h", k, i_resp_valid, d_resp_valid, i_resp_instr, rd[63:32]);
        end
      end else begin
        n_cmp++; if ({i_resp_valid, d_resp_valid, d_resp_data} !== {2'b01, rd}) begin
          n_fail++; $display("FAIL rr_route_%0d got iv=%b dv=%b data=%h want data %h", k, i_resp_valid, d_resp_valid, d_resp_data, rd);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_full();
    do_reset();
    d_req_valid = 1'b1; d_req_addr = 64'h100; d_req_op = 2'b10; d_req_mask = 8'h0F;
    repeat (OUTSTANDING) tick();
    i_req_valid = 1'b1;
    #1;
    n_cmp++; if ({mem_req_valid, i_req_ready, d_req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL full_block got valid/ir/dr %b want 000", {mem_req_valid, i_req_ready, d_req_ready});
    end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h1234;
    #1;
    n_cmp++; if (d_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got %b want 0", d_req_ready); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen got %b want 1", d_req_ready); end
    n_cmp++; if (d_resp_data !== 64'h1234) begin n_fail++; $display("FAIL full_resp got %h want 1234", d_resp_data); end
    drain();
  endtask

  task automatic test_push_pop();
    logic [63:0] rd;
    do_reset();
    d_req_valid = 1'b1; d_req_op = 2'b00; d_req_mask = 8'hFF;
    for (int k = 0; k < 2; k++) begin d_req_addr = 64'(k); tick(); end
    for (int k = 0; k < 10; k++) begin
      rd = {$urandom, $urandom};
      d_req_addr = 64'(k + 2);
      mem_resp_valid = 1'b1; mem_resp_data = rd; mem_resp_fault = 2'b01;
      #1;
      n_cmp++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_%0d got %b want 1", k, d_req_ready); end
      tick();
      n_cmp++; if ({d_resp_valid, d_resp_data} !== {1'b1, rd}) begin
        n_fail++; $display("FAIL pp_resp_%0d got v=%b %h want %h", k, d_resp_valid, d_resp_data, rd);
      end
    end
    d_req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (d_resp_valid !== 1'b1) begin n_fail++; $display("FAIL pp_tail_%0d got %b want 1", k, d_resp_valid); end
    end
    tick();
    n_cmp++; if ({d_resp_valid, err_orphan} !== 2'b01) begin
      n_fail++; $display("FAIL pp_count_two got dv/err %b want 01", {d_resp_valid, err_orphan});
    end
    idle();
  endtask

  task automatic test_orphan();
    do_reset();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF;
    tick();
    idle();
    n_cmp++; if ({i_resp_valid, d_resp_valid, err_orphan} !== 3'b001) begin
      n_fail++; $display("FAIL orphan_set got iv/dv/err %b want 001", {i_resp_valid, d_resp_valid, err_orphan});
    end
    tick(); tick();
    n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear got %b want 0", err_orphan); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_req_valid = 1'b1; i_req_pc = 64'h40;
    repeat (3) tick();
    idle();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 64'(k);
      tick();
      n_cmp++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin
        n_fail++; $display("FAIL rm_stale_%0d got iv/dv %b want 00", k, {i_resp_valid, d_resp_valid});
      end
    end
    idle();
    n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL rm_orphan got %b want 1", err_orphan); end
    i_req_valid = 1'b1; i_req_pc = 64'h3000;
    tick();
    idle();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFEF00D_0BADC0DE;
    tick();
    idle();
    n_cmp++; if ({i_resp_valid, i_resp_instr} !== {1'b1, 32'h0BADC0DE}) begin
      n_fail++; $display("FAIL rm_new_fetch got v=%b %h want 1 0badc0de", i_resp_valid, i_resp_instr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      RESET          = ($urandom_range(0, 299) != 0);
      i_req_valid    = $urandom_range(0, 1) == 1;
      i_req_pc       = {$urandom, $urandom};
      d_req_valid    = $urandom_range(0, 1) == 1;
      d_req_op       = 2'($urandom);
      d_req_mask     = 8'($urandom);
      d_req_addr     = {$urandom, $urandom};
      d_req_data     = {$urandom, $urandom};
      mem_req_ready  = $urandom_range(0, 3) != 0;
      mem_resp_valid = (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      mem_resp_data  = {$urandom, $urandom};
      mem_resp_fault = 2'($urandom);
      #1;
      exp_comb();
      n_cmp++; if ({mem_req_valid, i_req_ready, d_req_ready} !== {e_mvalid, e_iready, e_dready}) begin
        n_fail++; $display("FAIL rnd_handshake c=%0d got %b want %b", c, {mem_req_valid, i_req_ready, d_req_ready}, {e_mvalid, e_iready, e_dready});
      end
      if (e_mvalid) begin
        n_cmp++; if ({mem_req_op, mem_req_mask, mem_req_addr, mem_req_data} !== {e_op, e_mask, e_addr, e_data}) begin
          n_fail++; $display("FAIL rnd_fields c=%0d got %h/%h/%h/%h want %h/%h/%h/%h", c, mem_req_op, mem_req_mask, mem_req_addr, mem_req_data, e_op, e_mask, e_addr, e_data);
        end
      end
      tick();
      n_cmp++; if ({i_resp_valid, i_resp_instr, i_resp_fault} !== {m_iv, m_instr, m_ifault}) begin
        n_fail++; $display("FAIL rnd_i_resp c=%0d got %b/%h/%b want %b/%h/%b", c, i_resp_valid, i_resp_instr, i_resp_fault, m_iv, m_instr, m_ifault);
      end
      n_cmp++; if ({d_resp_valid, d_resp_data, d_resp_fault} !== {m_dv, m_ddata, m_dfault}) begin
        n_fail++; $display("FAIL rnd_d_resp c=%0d got %b/%h/%b want %b/%h/%b", c, d_resp_valid, d_resp_data, d_resp_fault, m_dv, m_ddata, m_dfault);
      end
      n_cmp++; if (err_orphan !== m_err) begin
        n_fail++; $display("FAIL rnd_err_orphan c=%0d got %b want %b", c, err_orphan, m_err);
      end
    end
    RESET = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_full();
    test_push_pop();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
